// File: rtl/buzzer_voice_sustain.sv
// Multi-channel buzzer voice with per-key sustain and sounding-note selection.
// Optional macro BUZZER_LAST_NOTE_PRIORITY_EN: select the most recently pressed note.

module buzzer_voice_channel #(
    parameter int CNT_W = 21
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             key_i,
    input  logic [CNT_W-1:0] hold_i,      // live hold register, used for sustain expiry
    input  logic [CNT_W-1:0] hold_rel_i,  // hold value seen by a channel releasing this edge
    output logic             ring_o,
    output logic             ring_d_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, SUSTAIN = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (key_i) state_d = HELD;
            end
            HELD: begin
                cnt_d = '0;
                if (!key_i) begin
                    if (hold_rel_i != '0) begin
                        state_d = SUSTAIN;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SUSTAIN: begin
                // A re-press wins over expiry so the note never drops out.
                if (key_i) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= hold_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign ring_o   = (state_q != IDLE);
    assign ring_d_o = (state_d != IDLE);
endmodule

module buzzer_voice_sustain #(
    parameter int CHANNELS    = 8,
    parameter int CNT_W       = 21,
    parameter int HOLD_CYCLES = 200000
) (
    input  logic                        iClk,
    input  logic                        iReset_n,
    input  logic [CHANNELS-1:0]         iKey,
    input  logic                        iHoldLoad,
    input  logic [CNT_W-1:0]            iHoldValue,
    output logic [CHANNELS-1:0]         oRing,
    output logic                        oNoteValid,
    output logic [$clog2(CHANNELS)-1:0] oNoteIdx,
    output logic                        oNoteNew
);
    localparam int IDX_W = $clog2(CHANNELS);

    logic [CNT_W-1:0]    hold_q, hold_rel;
    logic [CHANNELS-1:0] ring_d;
    logic                valid_q, valid_d, new_q, new_d;
    logic [IDX_W-1:0]    idx_q, idx_d, low_idx, sel_idx;

    assign hold_rel = iHoldLoad ? iHoldValue : hold_q;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) hold_q <= CNT_W'(HOLD_CYCLES);
        else if (iHoldLoad) hold_q <= iHoldValue;
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        buzzer_voice_channel #(.CNT_W(CNT_W)) u_ch (
            .clk_i     (iClk),
            .rst_n_i   (iReset_n),
            .key_i     (iKey[k]),
            .hold_i    (hold_q),
            .hold_rel_i(hold_rel),
            .ring_o    (oRing[k]),
            .ring_d_o  (ring_d[k])
        );
    end

    always_comb begin
        low_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--)
            if (ring_d[k]) low_idx = IDX_W'(k);
    end

`ifdef BUZZER_LAST_NOTE_PRIORITY_EN
    // A channel enters HELD exactly when its key is sampled high after an edge that sampled it low.
    logic [CHANNELS-1:0] key_q, entered;
    logic [IDX_W-1:0]    last_q, last_d, ent_idx;

    assign entered = iKey & ~key_q;

    always_comb begin
        ent_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--)
            if (entered[k]) ent_idx = IDX_W'(k);
        last_d  = (|entered) ? ent_idx : last_q;
        sel_idx = ring_d[last_d] ? last_d : low_idx;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            key_q  <= '0;
            last_q <= '0;
        end else begin
            key_q  <= iKey;
            last_q <= last_d;
        end
    end
`else
    assign sel_idx = low_idx;
`endif

    // Selection is taken from the next-state ring vector so it lines up with oRing.
    always_comb begin
        valid_d = |ring_d;
        idx_d   = valid_d ? sel_idx : idx_q;
        new_d   = valid_d && (!valid_q || (idx_d != idx_q));
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            new_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            new_q   <= new_d;
        end
    end

    assign oNoteValid = valid_q;
    assign oNoteIdx   = idx_q;
    assign oNoteNew   = new_q;
endmodule

// File: tb/tb_buzzer_voice_sustain.sv
// Bench for buzzer_voice_sustain: directed scenarios plus random keys against a timestamp model.
module tb_buzzer_voice_sustain;
    localparam int CH = 4;
    localparam int CW = 21;
    localparam int HC = 5;

    logic          iClk = 1'b0, iReset_n = 1'b0, iHoldLoad = 1'b0, oNoteValid, oNoteNew;
    logic [CH-1:0] iKey = '0, oRing;
    logic [CW-1:0] iHoldValue = '0;
    logic [1:0]    oNoteIdx;

    int checks = 0, failures = 0;

    buzzer_voice_sustain #(.CHANNELS(CH), .CNT_W(CW), .HOLD_CYCLES(HC)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iKey(iKey), .iHoldLoad(iHoldLoad),
        .iHoldValue(iHoldValue), .oRing(oRing), .oNoteValid(oNoteValid),
        .oNoteIdx(oNoteIdx), .oNoteNew(oNoteNew)
    );

    always #5 iClk = ~iClk;

    // Model: a key held means sounding; a released key sounds while the cycles since release
    // stay below the hold value in force at each edge.
    bit      held_m [CH];
    bit      sus_m  [CH];
    int      rel_m  [CH];
    int      cyc, hold_m, last_m;
    bit      last_v;
    logic [CH-1:0] exp_ring;
    logic    exp_v, exp_new;
    int      exp_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            held_m[k] = 0; sus_m[k] = 0; rel_m[k] = 0;
        end
        hold_m = HC; last_m = 0; last_v = 0;
        exp_ring = '0; exp_v = 0; exp_i = 0; exp_new = 0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] ent;
        int heff, lo, sel;
        logic v;
        ent = '0;
        cyc++;
        for (int k = 0; k < CH; k++) begin
            if (iKey[k]) begin
                if (!held_m[k]) ent[k] = 1'b1;
                held_m[k] = 1; sus_m[k] = 0;
            end else if (held_m[k]) begin
                held_m[k] = 0;
                heff = iHoldLoad ? int'(iHoldValue) : hold_m;
                sus_m[k] = (heff > 0);
                rel_m[k] = cyc;
            end else if (sus_m[k] && (cyc - rel_m[k]) >= hold_m) begin
                sus_m[k] = 0;
            end
        end
        if (iHoldLoad) hold_m = int'(iHoldValue);
        for (int k = 0; k < CH; k++) exp_ring[k] = held_m[k] | sus_m[k];
        v = |exp_ring;
        lo = 0;
        for (int k = CH - 1; k >= 0; k--) if (exp_ring[k]) lo = k;
        sel = lo;
`ifdef BUZZER_LAST_NOTE_PRIORITY_EN
        if (ent != '0) begin
            for (int k = CH - 1; k >= 0; k--) if (ent[k]) last_m = k;
            last_v = 1;
        end
        if (last_v && exp_ring[last_m]) sel = last_m;
`endif
        exp_new = v && (!exp_v || (sel != exp_i));
        if (v) exp_i = sel;
        exp_v = v;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ring"},  32'(oRing),      32'(exp_ring));
        chk({tag, ".valid"}, 32'(oNoteValid), 32'(exp_v));
        chk({tag, ".idx"},   32'(oNoteIdx),   32'(exp_i));
        chk({tag, ".new"},   32'(oNoteNew),   32'(exp_new));
    endtask

    task automatic step(input string tag);
        @(posedge iClk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic load_step(input string tag, input int v);
        iHoldLoad = 1'b1; iHoldValue = CW'(v);
        step(tag);
        iHoldLoad = 1'b0;
    endtask

    initial begin
        int rcnt, ncnt;
        cyc = 0;
        model_reset();
        #3;
        chk("reset.ring", 32'(oRing), 0);
        chk("reset.valid", 32'(oNoteValid), 0);
        chk("reset.idx", 32'(oNoteIdx), 0);
        chk("reset.new", 32'(oNoteNew), 0);
        #4 iReset_n = 1'b1;

        // Basic press, hold, 5-cycle sustain
        iKey = 4'b0001;
        step("p32_on");
        chk("p32_latency", 32'(oRing[0]), 1);
        ncnt = int'(oNoteNew);
        repeat (2) begin step("p32_hold"); ncnt += int'(oNoteNew); end
        iKey = 4'b0000;
        rcnt = 0;
        repeat (8) begin step("p32_rel"); rcnt += int'(oRing[0]); ncnt += int'(oNoteNew); end
        chk("p32_sustain_len", 32'(rcnt), HC);
        chk("p32_new_pulses", 32'(ncnt), 1);

        // Retrigger during sustain
        iKey = 4'b0001; step("p33_on");
        iKey = 4'b0000; repeat (3) step("p33_sus");
        iKey = 4'b0001; step("p33_re");
        chk("p33_nogap", 32'(oRing[0]), 1);
        step("p33_held");
        iKey = 4'b0000;
        rcnt = 0;
        repeat (8) begin step("p33_rel"); rcnt += int'(oRing[0]); end
        chk("p33_sustain_len", 32'(rcnt), HC);

        // Hold reload mid-sustain, then short and zero holds
        iKey = 4'b0010; step("p34_on");
        iKey = 4'b0000; repeat (4) step("p34_sus");
        load_step("p34_load2", 2);
        step("p34_expire");
        chk("p34_ch1_idle", 32'(oRing[1]), 0);
        iKey = 4'b0100; repeat (2) step("p34_ch2");
        iKey = 4'b0000;
        rcnt = 0;
        repeat (4) begin step("p34_ch2rel"); rcnt += int'(oRing[2]); end
        chk("p34_len2", 32'(rcnt), 2);
        load_step("p34_load0", 0);
        iKey = 4'b0001; step("p34_ch0");
        iKey = 4'b0000; step("p34_ch0rel");
        chk("p34_hold0_drop", 32'(oRing[0]), 0);
        load_step("p34_load5", HC);

        // Note selection
        iKey = 4'b0100; step("p35_a");
        chk("p35_idx2", 32'(oNoteIdx), 2);
        iKey = 4'b0110; step("p35_b");
        chk("p35_idx1", 32'(oNoteIdx), 1);
        chk("p35_new", 32'(oNoteNew), 1);
        iKey = 4'b0100;
        repeat (6) step("p35_rel1");
        chk("p35_back2", 32'(oNoteIdx), 2);
        iKey = 4'b0000; repeat (7) step("p35_drain");

        // Async reset in the middle of a ch3 sustain
        iKey = 4'b1000; step("p36_on");
        iKey = 4'b0000; repeat (2) step("p36_sus");
        load_step("p36_load3", 3);
        #2 iReset_n = 1'b0;
        #1;
        model_reset();
        check_all("p36_async");
        #2 iReset_n = 1'b1;
        iKey = 4'b1000; step("p36_after");
        iKey = 4'b0000;
        rcnt = 0;
        repeat (8) begin step("p36_rel"); rcnt += int'(oRing[3]); end
        chk("p36_hold_reloaded", 32'(rcnt), HC);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < CH; k++)
                if ($urandom_range(0, 5) == 0) iKey[k] = ~iKey[k];
            if ($urandom_range(0, 15) == 0) load_step("rnd_load", $urandom_range(0, 7));
            else step("rnd");
        end
        iKey = '0;
        repeat (10) step("rnd_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
